// File: rtl/maq_est_y_modos_pkg.sv
// Shared definitions for the virtual-pet state machine: pet state and mode
// encodings, stat ceiling, and the hex-to-7-segment glyph decoder.
package maq_est_y_modos_pkg;

    typedef enum logic [1:0] {
        FELIZ      = 2'd0,
        HAMBRIENTO = 2'd1,
        ENFERMO    = 2'd2,
        MUERTO     = 2'd3
    } estado_t;

    typedef enum logic {
        MODO_NORMAL = 1'b0,
        MODO_TEST   = 1'b1
    } modo_t;

    localparam logic [2:0] MAX_LVL = 3'd4;
    localparam logic [2:0] UMBRAL  = 3'd3;

    // Active-low segments ordered {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_sseg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // Death outranks sickness, sickness outranks hunger
    function automatic estado_t clasificar(input logic [2:0] comida, input logic [2:0] salud);
        estado_t e;
        if (salud == 3'd0) begin
            e = MUERTO;
        end else if (salud < UMBRAL) begin
            e = ENFERMO;
        end else if (comida < UMBRAL) begin
            e = HAMBRIENTO;
        end else begin
            e = FELIZ;
        end
        return e;
    endfunction

endpackage

// File: rtl/maq_est_y_modos_display_7seg.sv
// Four-digit multiplexed 7-segment driver; one digit active (anode low) at a
// time, advancing every REFRESH_CYCLES clocks.
module display_7seg
    import maq_est_y_modos_pkg::*;
#(
    parameter int REFRESH_CYCLES = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    output logic [6:0] sseg,
    output logic [3:0] an
);

    logic [31:0] refresh_cnt;
    logic [1:0]  sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt <= 32'd0;
            sel         <= 2'd0;
        end else if (refresh_cnt == 32'(REFRESH_CYCLES - 1)) begin
            refresh_cnt <= 32'd0;
            sel         <= sel + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 32'd1;
        end
    end

    // Outputs decode straight from the select register so reset shows digit0 at once
    always_comb begin
        an   = 4'b1110;
        sseg = hex_to_sseg(digit0);
        case (sel)
            2'd1: begin
                an   = 4'b1101;
                sseg = hex_to_sseg(digit1);
            end
            2'd2: begin
                an   = 4'b1011;
                sseg = hex_to_sseg(digit2);
            end
            2'd3: begin
                an   = 4'b0111;
                sseg = hex_to_sseg(digit3);
            end
            default: begin
                an   = 4'b1110;
                sseg = hex_to_sseg(digit0);
            end
        endcase
    end

endmodule

// File: rtl/maq_est_y_modos.sv
// Virtual pet: food/health stats with timed decay in Normal mode, direct stat
// editing in Test mode, registered pet state and a multiplexed display.
module maq_est_y_modos
    import maq_est_y_modos_pkg::*;
#(
    parameter int DECAY_CYCLES   = 1000,
    parameter int TEST_HOLD      = 5,
    parameter int REFRESH_CYCLES = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Boton_Comida,
    input  logic       Boton_Medicina,
    input  logic       Boton_Test,
    output logic [6:0] sseg,
    output logic [3:0] an,
    output logic [1:0] estado,
    output logic       modo
);

    logic [2:0]  sync1;
    logic [2:0]  sync2;
    logic [1:0]  prev;
    logic        edge_comida;
    logic        edge_medicina;
    logic        test_level;

    logic [2:0]  comida_q, comida_next;
    logic [2:0]  salud_q, salud_next;
    estado_t     estado_q, estado_next;
    modo_t       modo_q, modo_next;
    logic [31:0] decay_cnt, decay_next;
    logic [31:0] hold_cnt, hold_next;
    logic        tick;
    logic        toggle;
    logic        dec_salud;

    // Buttons are asynchronous: two flops, then a one-cycle rising-edge pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
            prev  <= 2'b00;
        end else begin
            sync1 <= {Boton_Test, Boton_Medicina, Boton_Comida};
            sync2 <= sync1;
            prev  <= sync2[1:0];
        end
    end

    assign edge_comida   = sync2[0] & ~prev[0];
    assign edge_medicina = sync2[1] & ~prev[1];
    assign test_level    = sync2[2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            comida_q  <= MAX_LVL;
            salud_q   <= MAX_LVL;
            estado_q  <= FELIZ;
            modo_q    <= MODO_NORMAL;
            decay_cnt <= 32'd0;
            hold_cnt  <= 32'd0;
        end else begin
            comida_q  <= comida_next;
            salud_q   <= salud_next;
            estado_q  <= estado_next;
            modo_q    <= modo_next;
            decay_cnt <= decay_next;
            hold_cnt  <= hold_next;
        end
    end

    // Hold counter saturates at TEST_HOLD so a long press toggles only once
    always_comb begin
        hold_next = hold_cnt;
        toggle    = 1'b0;
        if (!test_level) begin
            hold_next = 32'd0;
        end else begin
            toggle = (hold_cnt == 32'(TEST_HOLD - 1));
            if (hold_cnt < 32'(TEST_HOLD)) begin
                hold_next = hold_cnt + 32'd1;
            end
        end
        modo_next = toggle ? ((modo_q == MODO_NORMAL) ? MODO_TEST : MODO_NORMAL) : modo_q;
    end

    always_comb begin
        tick       = (modo_q == MODO_NORMAL) && (decay_cnt == 32'(DECAY_CYCLES - 1));
        decay_next = decay_cnt + 32'd1;
        if (modo_q == MODO_TEST || toggle || tick) begin
            decay_next = 32'd0;
        end
    end

    // A feed in the same cycle as a tick absorbs that tick entirely
    always_comb begin
        comida_next = comida_q;
        salud_next  = salud_q;
        dec_salud   = 1'b0;
        if (modo_q == MODO_TEST) begin
            if (edge_comida) begin
                comida_next = (comida_q == 3'd0) ? MAX_LVL : comida_q - 3'd1;
            end
            if (edge_medicina) begin
                salud_next = (salud_q == 3'd0) ? MAX_LVL : salud_q - 3'd1;
            end
        end else if (salud_q != 3'd0) begin
            if (tick && !edge_comida && comida_q != 3'd0) begin
                comida_next = comida_q - 3'd1;
            end else if (edge_comida && !tick && comida_q != MAX_LVL) begin
                comida_next = comida_q + 3'd1;
            end
            dec_salud = tick && !edge_comida && (comida_q == 3'd0);
            if (dec_salud && !edge_medicina) begin
                salud_next = salud_q - 3'd1;
            end else if (edge_medicina && !dec_salud && salud_q != MAX_LVL) begin
                salud_next = salud_q + 3'd1;
            end
        end
        estado_next = clasificar(comida_q, salud_q);
    end

    assign estado = estado_q;
    assign modo   = modo_q;

    display_7seg #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_display (
        .clk   (clk),
        .reset (reset),
        .digit0({1'b0, comida_q}),
        .digit1({1'b0, salud_q}),
        .digit2({2'b00, estado_q}),
        .digit3({3'b000, modo_q}),
        .sseg  (sseg),
        .an    (an)
    );

endmodule

// File: tb/tb_maq_est_y_modos.sv
// Directed bench for maq_est_y_modos with short decay/hold/refresh periods;
// stats are observed through the multiplexed display.
module tb_maq_est_y_modos;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001;

    logic       clk;
    logic       reset;
    logic       Boton_Comida;
    logic       Boton_Medicina;
    logic       Boton_Test;
    logic [6:0] sseg;
    logic [3:0] an;
    logic [1:0] estado;
    logic       modo;

    int total;
    int bad;
    int cyc;

    maq_est_y_modos #(
        .DECAY_CYCLES  (20),
        .TEST_HOLD     (5),
        .REFRESH_CYCLES(4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .Boton_Comida  (Boton_Comida),
        .Boton_Medicina(Boton_Medicina),
        .Boton_Test    (Boton_Test),
        .sseg          (sseg),
        .an            (an),
        .estado        (estado),
        .modo          (modo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges counted since the last reset release
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b1;
        Boton_Comida   = 1'b0;
        Boton_Medicina = 1'b0;
        Boton_Test     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic press_comida();
        Boton_Comida = 1'b1;
        repeat (3) @(negedge clk);
        Boton_Comida = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic press_medicina();
        Boton_Medicina = 1'b1;
        repeat (3) @(negedge clk);
        Boton_Medicina = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic read_digits(output logic [6:0] d0, output logic [6:0] d1,
                               output logic [6:0] d2, output logic [6:0] d3);
        d0 = 7'bx;
        d1 = 7'bx;
        d2 = 7'bx;
        d3 = 7'bx;
        for (int i = 0; i < 16; i++) begin
            total++;
            case (an)
                4'b1110: d0 = sseg;
                4'b1101: d1 = sseg;
                4'b1011: d2 = sseg;
                4'b0111: d3 = sseg;
                default: begin
                    bad++;
                    $display("[TB] FAIL an_onehot: got %b want exactly one low bit", an);
                end
            endcase
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        Boton_Comida   = 1'b0;
        Boton_Medicina = 1'b0;
        Boton_Test     = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (an !== 4'b1110) begin bad++; $display("[TB] FAIL reset_an: got %b want 1110", an); end
        total++;
        if (sseg !== G4) begin bad++; $display("[TB] FAIL reset_sseg: got %b want %b", sseg, G4); end
        total++;
        if (estado !== 2'd0) begin bad++; $display("[TB] FAIL reset_estado: got %0d want 0", estado); end
        total++;
        if (modo !== 1'b0) begin bad++; $display("[TB] FAIL reset_modo: got %0d want 0", modo); end
    endtask

    task automatic test_display();
        logic [3:0] an_exp [4];
        logic [6:0] sg_exp [4];
        an_exp[0] = 4'b1110; an_exp[1] = 4'b1101; an_exp[2] = 4'b1011; an_exp[3] = 4'b0111;
        sg_exp[0] = G4;      sg_exp[1] = G4;      sg_exp[2] = G0;      sg_exp[3] = G0;
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (an !== an_exp[i/4]) begin
                bad++;
                $display("[TB] FAIL display_an[%0d]: got %b want %b", i, an, an_exp[i/4]);
            end
            total++;
            if (sseg !== sg_exp[i/4]) begin
                bad++;
                $display("[TB] FAIL display_sseg[%0d]: got %b want %b", i, sseg, sg_exp[i/4]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_decay();
        logic [6:0] d0, d1, d2, d3;
        do_reset();
        wait_cyc(40);
        total++;
        if (estado !== 2'd0) begin bad++; $display("[TB] FAIL decay_estado_lag: got %0d want 0", estado); end
        wait_cyc(41);
        total++;
        if (estado !== 2'd1) begin bad++; $display("[TB] FAIL decay_hambriento: got %0d want 1", estado); end
        wait_cyc(62);
        read_digits(d0, d1, d2, d3);
        total++;
        if (d0 !== G1) begin bad++; $display("[TB] FAIL decay_comida1: got %b want %b", d0, G1); end
        total++;
        if (d1 !== G4) begin bad++; $display("[TB] FAIL decay_salud4: got %b want %b", d1, G4); end
        total++;
        if (d2 !== G1) begin bad++; $display("[TB] FAIL decay_digit_estado: got %b want %b", d2, G1); end
        total++;
        if (d3 !== G0) begin bad++; $display("[TB] FAIL decay_digit_modo: got %b want %b", d3, G0); end
        wait_cyc(160);
        total++;
        if (estado !== 2'd2) begin bad++; $display("[TB] FAIL decay_enfermo: got %0d want 2", estado); end
        wait_cyc(161);
        total++;
        if (estado !== 2'd3) begin bad++; $display("[TB] FAIL decay_muerto: got %0d want 3", estado); end
        for (int i = 0; i < 10; i++) press_comida();
        total++;
        if (estado !== 2'd3) begin bad++; $display("[TB] FAIL muerto_absorbing: got %0d want 3", estado); end
        read_digits(d0, d1, d2, d3);
        total++;
        if (d0 !== G0) begin bad++; $display("[TB] FAIL muerto_comida_frozen: got %b want %b", d0, G0); end
        total++;
        if (d1 !== G0) begin bad++; $display("[TB] FAIL muerto_salud: got %b want %b", d1, G0); end
        total++;
        if (d2 !== G3) begin bad++; $display("[TB] FAIL muerto_digit_estado: got %b want %b", d2, G3); end
    endtask

    task automatic test_feed();
        do_reset();
        press_comida();
        press_comida();
        wait_cyc(16);
        total++;
        if (an !== 4'b1110 || sseg !== G4) begin
            bad++; $display("[TB] FAIL feed_saturate: got an=%b sseg=%b want an=1110 sseg=%b", an, sseg, G4);
        end
        wait_cyc(32);
        total++;
        if (sseg !== G3) begin bad++; $display("[TB] FAIL feed_tick1: got %b want %b", sseg, G3); end
        wait_cyc(48);
        total++;
        if (sseg !== G2) begin bad++; $display("[TB] FAIL feed_tick2: got %b want %b", sseg, G2); end
        total++;
        if (estado !== 2'd1) begin bad++; $display("[TB] FAIL feed_estado: got %0d want 1", estado); end
        // Feed edge lands on the same clock as the tick at edge 60
        wait_cyc(57);
        press_comida();
        wait_cyc(64);
        total++;
        if (sseg !== G2) begin bad++; $display("[TB] FAIL tick_and_feed: got %b want %b", sseg, G2); end
        wait_cyc(66);
        Boton_Comida   = 1'b1;
        Boton_Medicina = 1'b1;
        repeat (3) @(negedge clk);
        Boton_Comida   = 1'b0;
        Boton_Medicina = 1'b0;
        wait_cyc(72);
        total++;
        if (estado !== 2'd0) begin bad++; $display("[TB] FAIL both_buttons: got %0d want 0", estado); end
        wait_cyc(82);
        total++;
        if (estado !== 2'd1) begin bad++; $display("[TB] FAIL after_both_tick: got %0d want 1", estado); end
    endtask

    task automatic test_mode();
        logic [6:0] d0, d1, d2, d3;
        do_reset();
        Boton_Test = 1'b1;
        repeat (4) @(negedge clk);
        Boton_Test = 1'b0;
        wait_cyc(10);
        total++;
        if (modo !== 1'b0) begin bad++; $display("[TB] FAIL short_hold: got %0d want 0", modo); end
        Boton_Test = 1'b1;
        wait_cyc(24);
        total++;
        if (modo !== 1'b1) begin bad++; $display("[TB] FAIL hold_toggle: got %0d want 1", modo); end
        wait_cyc(30);
        Boton_Test = 1'b0;
        wait_cyc(40);
        total++;
        if (modo !== 1'b1) begin bad++; $display("[TB] FAIL single_toggle: got %0d want 1", modo); end
        for (int i = 0; i < 3; i++) press_medicina();
        wait_cyc(60);
        total++;
        if (estado !== 2'd2) begin bad++; $display("[TB] FAIL test_salud1: got %0d want 2", estado); end
        wait_cyc(64);
        read_digits(d0, d1, d2, d3);
        total++;
        if (d0 !== G4) begin bad++; $display("[TB] FAIL test_comida_held: got %b want %b", d0, G4); end
        total++;
        if (d1 !== G1) begin bad++; $display("[TB] FAIL test_salud_digit: got %b want %b", d1, G1); end
        total++;
        if (d3 !== G1) begin bad++; $display("[TB] FAIL test_modo_digit: got %b want %b", d3, G1); end
        press_medicina();
        total++;
        if (estado !== 2'd3) begin bad++; $display("[TB] FAIL test_salud0: got %0d want 3", estado); end
        press_medicina();
        wait_cyc(94);
        total++;
        if (estado !== 2'd0) begin bad++; $display("[TB] FAIL test_wrap: got %0d want 0", estado); end
        wait_cyc(96);
        read_digits(d0, d1, d2, d3);
        total++;
        if (d1 !== G4) begin bad++; $display("[TB] FAIL test_wrap_digit: got %b want %b", d1, G4); end
        for (int i = 0; i < 3; i++) press_medicina();
        press_comida();
        wait_cyc(138);
        total++;
        if (estado !== 2'd2) begin bad++; $display("[TB] FAIL pre_reset_estado: got %0d want 2", estado); end
        // Mid-cycle reset: results must appear before the next rising edge
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (modo !== 1'b0) begin bad++; $display("[TB] FAIL async_modo: got %0d want 0", modo); end
        total++;
        if (estado !== 2'd0) begin bad++; $display("[TB] FAIL async_estado: got %0d want 0", estado); end
        total++;
        if (an !== 4'b1110) begin bad++; $display("[TB] FAIL async_an: got %b want 1110", an); end
        total++;
        if (sseg !== G4) begin bad++; $display("[TB] FAIL async_sseg: got %b want %b", sseg, G4); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        read_digits(d0, d1, d2, d3);
        total++;
        if (d1 !== G4) begin bad++; $display("[TB] FAIL async_salud: got %b want %b", d1, G4); end
        total++;
        if (d3 !== G0) begin bad++; $display("[TB] FAIL async_modo_digit: got %b want %b", d3, G0); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_display();
        test_decay();
        test_feed();
        test_mode();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/maq_est_y_modos.md
MAQ_EST_Y_MODOS -- requirements
Module: maq_est_y_modos

Interface
REQ-001 SHALL have parameter DECAY_CYCLES, default 1000: clock cycles between hunger decay ticks in Normal mode.
REQ-002 SHALL have parameter TEST_HOLD, default 5: consecutive cycles Boton_Test must be high to toggle mode.
REQ-003 SHALL have parameter REFRESH_CYCLES, default 250: cycles each display digit stays active.
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port Boton_Comida, input, 1 bit: feed button, asynchronous, active-high.
REQ-007 SHALL have port Boton_Medicina, input, 1 bit: medicine button, asynchronous, active-high.
REQ-008 SHALL have port Boton_Test, input, 1 bit: test-mode button, asynchronous, active-high.
REQ-009 SHALL have port sseg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port an, output, 4 bits: digit anodes, active-low, exactly one low at a time.
REQ-011 SHALL have port estado, output, 2 bits: pet state; FELIZ=0, HAMBRIENTO=1, ENFERMO=2, MUERTO=3.
REQ-012 SHALL have port modo, output, 1 bit: 0 = Normal, 1 = Test.

Function
REQ-013 SHALL pass each button through a 2-flop synchronizer, then a rising-edge detector; a button edge SHALL update stats exactly 3 clk edges after the input rises.
REQ-014 SHALL keep stats comida and salud, each 3 bits, range 0..4.
REQ-015 Normal mode: a free-running counter SHALL produce one tick every DECAY_CYCLES cycles. On each tick, comida decrements, saturating at 0; if comida was already 0, salud decrements instead, saturating at 0.
REQ-016 Normal mode: a Comida edge SHALL add 1 to comida and a Medicina edge SHALL add 1 to salud, each saturating at 4.
REQ-017 A tick and a Comida edge in the same cycle SHALL leave comida unchanged (net 0). Simultaneous Comida and Medicina edges SHALL both apply.
REQ-018 estado SHALL be registered, updating one cycle after the stats, with priority MUERTO (salud==0) > ENFERMO (salud<3) > HAMBRIENTO (comida<3) > FELIZ.
REQ-019 In Normal mode, MUERTO SHALL be absorbing: stats freeze and buttons are ignored until reset or a mode toggle.
REQ-020 Boton_Test (synchronized) high for TEST_HOLD consecutive cycles SHALL toggle modo exactly once per hold; further toggling requires release and a new hold. Shorter pulses SHALL have no effect.
REQ-021 Test mode: decay ticks SHALL be suppressed and the decay counter held at 0. A Comida edge decrements comida and a Medicina edge decrements salud, each wrapping 0->4. MUERTO is not absorbing.
REQ-022 Leaving Test mode SHALL keep the current stats and restart the decay counter from 0.
REQ-023 Display: digit0 = comida, digit1 = salud, digit2 = estado, digit3 = modo, each shown as a hex 7-segment glyph. Digits rotate 0->1->2->3->0 every REFRESH_CYCLES cycles.

Reset
REQ-024 While reset is high, the outputs SHALL be comida=4, salud=4, estado=FELIZ, modo=0, an=4'b1110, sseg=glyph "4" (7'b0011001), with all counters and synchronizers at 0.
REQ-025 Reset asserted mid-operation, in either mode, SHALL return everything to the REQ-024 values immediately, with no clock edge needed.

Structure
REQ-026 A shared package SHALL hold the estado encodings, MAX_LVL=4 and the hex-to-7-segment decode function.
REQ-027 Display multiplexing SHALL live in one sub-module, display_7seg (inputs: four 4-bit digits; outputs: sseg, an).

Verification (bench parameters: DECAY_CYCLES=20, TEST_HOLD=5, REFRESH_CYCLES=4)
REQ-028 Release reset, no buttons for 60 cycles -> comida reaches 1 and estado becomes HAMBRIENTO (1); after 5 more ticks estado becomes MUERTO (3) and stays there after 10 Comida presses.
REQ-029 From reset, apply 2 Comida presses, then run 40 cycles -> comida goes 4->4 (saturated) and then to 2 after the 2 ticks, estado=1.
REQ-030 Hold Boton_Test 4 cycles -> modo stays 0; hold it 20 cycles -> modo=1 (one toggle); 3 Medicina presses -> salud goes 4->1, estado=2; a fourth press -> salud=0, estado=3; a fifth press -> salud=4.
REQ-031 Assert reset asynchronously while in Test mode with salud=1 -> modo=0, salud=4, estado=0 and an=1110 before the next clk edge.
REQ-032 Observe an and sseg for 16 cycles after reset -> an sequence 1110, 1101, 1011, 0111 with 4 cycles each; sseg shows "4", "4", "0", "0".
